// File: rtl/idli_pred_rf_m.sv
// ---------------------------------------------------------------------------
// idli_pred_rf_m
//   Parametrised predicate register file with a single-entry shadow copy.
//   Registers hold 1-bit predicates and can be written with SET/AND/OR/XOR
//   read-modify-write operations. The top register can be hardwired to one.
//   The shadow saves all predicates on interrupt entry and restores them on
//   exit.
//
// Ports
//   i_prf_gck         clock, all state updates on the rising edge
//   i_prf_rst_n       synchronous active-low reset
//   i_prf_rd_idx      NUM_RD packed read indices, port k at [k*IDX_W +: IDX_W]
//   o_prf_rd_data     combinational read data, bit k for port k
//   i_prf_wr_en       write enable
//   i_prf_wr_idx      write index
//   i_prf_wr_op       0=SET 1=AND 2=OR 3=XOR
//   i_prf_wr_data     write operand
//   i_prf_save        capture all registers into the shadow
//   i_prf_restore     reload all registers from the shadow
//   o_prf_shadow_vld  shadow holds a saved snapshot
//   o_prf_shadow_ovf  sticky: a save hit an already valid shadow
// ---------------------------------------------------------------------------
module idli_pred_rf_m #(
  parameter int NUM_PREGS = 4,
  parameter int NUM_RD    = 2,
  parameter int CONST_ONE = 1,
  parameter int BYPASS    = 0,
  localparam int IDX_W    = (NUM_PREGS > 2) ? $clog2(NUM_PREGS) : 1
) (
  input  logic                    i_prf_gck,
  input  logic                    i_prf_rst_n,
  input  logic [NUM_RD*IDX_W-1:0] i_prf_rd_idx,
  output logic [NUM_RD-1:0]       o_prf_rd_data,
  input  logic                    i_prf_wr_en,
  input  logic [IDX_W-1:0]        i_prf_wr_idx,
  input  logic [1:0]              i_prf_wr_op,
  input  logic                    i_prf_wr_data,
  input  logic                    i_prf_save,
  input  logic                    i_prf_restore,
  output logic                    o_prf_shadow_vld,
  output logic                    o_prf_shadow_ovf
);

  // The constant register, when present, has no storage behind it.
  localparam bit HAS_CONST = (CONST_ONE != 0);
  localparam bit HAS_BYP   = (BYPASS != 0);
  localparam int NUM_STORE = HAS_CONST ? NUM_PREGS - 1 : NUM_PREGS;

  typedef enum logic [1:0] {OP_SET, OP_AND, OP_OR, OP_XOR} wr_op_e;
  typedef enum logic {SH_EMPTY, SH_FULL} sh_state_e;

  logic [NUM_STORE-1:0] preg_q, preg_d;
  logic [NUM_STORE-1:0] shadow_q, shadow_d;
  sh_state_e            sh_state_q, sh_state_d;
  logic                 shadow_ovf_q, shadow_ovf_d;

  logic [NUM_PREGS-1:0] preg_view;
  logic                 restore_act;
  logic                 save_act;
  logic                 wr_writable;
  logic                 wr_ok;
  logic                 wr_old;
  logic                 wr_new;
  wr_op_e               wr_op;

  // Select one bit of the architectural view; indices past the end read 0.
  function automatic logic pick(input logic [NUM_PREGS-1:0] v,
                                input logic [IDX_W-1:0]     idx);
    logic r;
    r = 1'b0;
    for (int j = 0; j < NUM_PREGS; j++) begin
      if (idx == IDX_W'(j)) r = v[j];
    end
    return r;
  endfunction

  // Architectural view: stored bits plus the hardwired top register.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    preg_view = '0;
    preg_view[NUM_STORE-1:0] = preg_q;
    if (HAS_CONST) preg_view[NUM_PREGS-1] = 1'b1;
  end

  // Write/save/restore decision and next-state computation.
  always_comb begin
    // A restore only counts while a snapshot exists; when it counts it
    // swallows any save or write presented in the same cycle.
    restore_act = i_prf_restore && (sh_state_q == SH_FULL);
    save_act    = i_prf_save && !restore_act;

    wr_writable = 1'b0;
    for (int j = 0; j < NUM_STORE; j++) begin
      if (i_prf_wr_idx == IDX_W'(j)) wr_writable = 1'b1;
    end
    wr_ok = i_prf_wr_en && wr_writable && !restore_act;

    wr_old = pick(preg_view, i_prf_wr_idx);
    wr_op  = wr_op_e'(i_prf_wr_op);
    case (wr_op)
      OP_SET:  wr_new = i_prf_wr_data;
      OP_AND:  wr_new = wr_old & i_prf_wr_data;
      OP_OR:   wr_new = wr_old | i_prf_wr_data;
      OP_XOR:  wr_new = wr_old ^ i_prf_wr_data;
      default: wr_new = i_prf_wr_data;
    endcase

    preg_d       = preg_q;
    shadow_d     = shadow_q;
    sh_state_d   = sh_state_q;
    shadow_ovf_d = shadow_ovf_q;

    if (restore_act) begin
      preg_d     = shadow_q;
      sh_state_d = SH_EMPTY;
    end else begin
      if (save_act) begin
        // Shadow takes the pre-write values of this cycle.
        shadow_d   = preg_q;
        sh_state_d = SH_FULL;
        if (sh_state_q == SH_FULL) shadow_ovf_d = 1'b1;
      end
      for (int j = 0; j < NUM_STORE; j++) begin
        if (wr_ok && (i_prf_wr_idx == IDX_W'(j))) preg_d[j] = wr_new;
      end
    end
  end

  // Read ports, with optional same-cycle forwarding of the write result.
  always_comb begin
    o_prf_rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      o_prf_rd_data[k] = pick(preg_view, i_prf_rd_idx[k*IDX_W +: IDX_W]);
      if (HAS_BYP && wr_ok && (i_prf_wr_idx == i_prf_rd_idx[k*IDX_W +: IDX_W]))
        o_prf_rd_data[k] = wr_new;
    end
  end

  always_ff @(posedge i_prf_gck) begin
    if (!i_prf_rst_n) begin
      // NOTE: the shadow is a handful of flops, not a RAM, so it is reset
      // along with everything else and never exposes stale contents.
      preg_q       <= '0;
      shadow_q     <= '0;
      sh_state_q   <= SH_EMPTY;
      shadow_ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      preg_q       <= preg_d;
      shadow_q     <= shadow_d;
      sh_state_q   <= sh_state_d;
      shadow_ovf_q <= shadow_ovf_d;
    end
  end

  assign o_prf_shadow_vld = (sh_state_q == SH_FULL);
  assign o_prf_shadow_ovf = shadow_ovf_q;

endmodule

// File: tb/tb_idli_pred_rf_m.sv
// ---------------------------------------------------------------------------
// tb_idli_pred_rf_m
//   Three instances: default (4 regs, 2 ports, const one), a bypassing
//   8-register 3-port file, and a 5-register file without the constant
//   register (out-of-range indices). A behavioural model tracks each one.
// ---------------------------------------------------------------------------
module tb_idli_pred_rf_m;

  localparam int ND = 3;
  localparam int NP [ND] = '{4, 8, 5};
  localparam int NR [ND] = '{2, 3, 1};
  localparam int IW [ND] = '{2, 3, 3};
  localparam bit C1 [ND] = '{1'b1, 1'b1, 1'b0};
  localparam bit BP [ND] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ND-1:0][2:0][2:0] rd_idx;
  logic [ND-1:0]           wr_en;
  logic [ND-1:0][2:0]      wr_idx;
  logic [ND-1:0][1:0]      wr_op;
  logic [ND-1:0]           wr_data;
  logic [ND-1:0]           save;
  logic [ND-1:0]           restore;
  logic [ND-1:0]           vld;
  logic [ND-1:0]           ovf;
  logic [1:0]              a_rd;
  logic [2:0]              b_rd;
  logic [0:0]              c_rd;

  idli_pred_rf_m #(.NUM_PREGS(4), .NUM_RD(2), .CONST_ONE(1), .BYPASS(0)) u_a (
    .i_prf_gck(clk), .i_prf_rst_n(rst_n),
    .i_prf_rd_idx({rd_idx[0][1][1:0], rd_idx[0][0][1:0]}),
    .o_prf_rd_data(a_rd),
    .i_prf_wr_en(wr_en[0]), .i_prf_wr_idx(wr_idx[0][1:0]),
    .i_prf_wr_op(wr_op[0]), .i_prf_wr_data(wr_data[0]),
    .i_prf_save(save[0]), .i_prf_restore(restore[0]),
    .o_prf_shadow_vld(vld[0]), .o_prf_shadow_ovf(ovf[0]));

  idli_pred_rf_m #(.NUM_PREGS(8), .NUM_RD(3), .CONST_ONE(1), .BYPASS(1)) u_b (
    .i_prf_gck(clk), .i_prf_rst_n(rst_n),
    .i_prf_rd_idx({rd_idx[1][2], rd_idx[1][1], rd_idx[1][0]}),
    .o_prf_rd_data(b_rd),
    .i_prf_wr_en(wr_en[1]), .i_prf_wr_idx(wr_idx[1]),
    .i_prf_wr_op(wr_op[1]), .i_prf_wr_data(wr_data[1]),
    .i_prf_save(save[1]), .i_prf_restore(restore[1]),
    .o_prf_shadow_vld(vld[1]), .o_prf_shadow_ovf(ovf[1]));

  idli_pred_rf_m #(.NUM_PREGS(5), .NUM_RD(1), .CONST_ONE(0), .BYPASS(0)) u_c (
    .i_prf_gck(clk), .i_prf_rst_n(rst_n),
    .i_prf_rd_idx(rd_idx[2][0]),
    .o_prf_rd_data(c_rd),
    .i_prf_wr_en(wr_en[2]), .i_prf_wr_idx(wr_idx[2]),
    .i_prf_wr_op(wr_op[2]), .i_prf_wr_data(wr_data[2]),
    .i_prf_save(save[2]), .i_prf_restore(restore[2]),
    .o_prf_shadow_vld(vld[2]), .o_prf_shadow_ovf(ovf[2]));

  // Reference model state.
  bit m_reg [ND][8];
  bit m_sh  [ND][8];
  bit m_vld [ND];
  bit m_ovf [ND];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_rd(input int d, input int k);
    logic r;
    case (d)
      0:       r = a_rd[k[0]];
      1:       r = b_rd[k[1:0]];
      default: r = c_rd[0];
    endcase
    return r;
  endfunction

  // A write lands if enabled, in range, not the constant register, and not
  // overridden by a restore of a valid snapshot.
  function automatic bit m_wr_ok(input int d);
    int idx;
    idx = int'(wr_idx[d]);
    return wr_en[d] && (idx < NP[d]) && !(C1[d] && idx == NP[d] - 1)
           && !(restore[d] && m_vld[d]);
  endfunction

  function automatic bit m_new(input int d);
    bit old, v;
    old = m_reg[d][wr_idx[d]];
    case (int'(wr_op[d]))
      0:       v = wr_data[d];
      1:       v = old & wr_data[d];
      2:       v = old | wr_data[d];
      default: v = old ^ wr_data[d];
    endcase
    return v;
  endfunction

  function automatic bit m_read(input int d, input int idx);
    if (idx >= NP[d]) return 1'b0;
    if (C1[d] && idx == NP[d] - 1) return 1'b1;
    if (BP[d] && m_wr_ok(d) && int'(wr_idx[d]) == idx) return m_new(d);
    return m_reg[d][idx];
  endfunction

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < NR[d]; k++)
        check($sformatf("dut%0d rd%0d idx%0d", d, k, rd_idx[d][k]),
              get_rd(d, k), m_read(d, int'(rd_idx[d][k])));
      check($sformatf("dut%0d shadow_vld", d), vld[d], m_vld[d]);
      check($sformatf("dut%0d shadow_ovf", d), ovf[d], m_ovf[d]);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin
          m_reg[d][i] = 1'b0;
          m_sh[d][i]  = 1'b0;
        end
        m_vld[d] = 1'b0;
        m_ovf[d] = 1'b0;
      end else begin
        bit ok, nv;
        ok = m_wr_ok(d);
        nv = m_new(d);
        if (restore[d] && m_vld[d]) begin
          for (int i = 0; i < 8; i++) m_reg[d][i] = m_sh[d][i];
          m_vld[d] = 1'b0;
        end else begin
          if (save[d]) begin
            if (m_vld[d]) m_ovf[d] = 1'b1;
            for (int i = 0; i < 8; i++) m_sh[d][i] = m_reg[d][i];
            m_vld[d] = 1'b1;
          end
          if (ok) m_reg[d][wr_idx[d]] = nv;
        end
      end
    end
  endtask

  // Inputs are set just after a falling edge; check, clock, update model.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_all();
    rd_idx = '0; wr_en = '0; wr_idx = '0; wr_op = '0; wr_data = '0;
    save = '0; restore = '0;
  endtask

  task automatic set_wr(input int d, input bit en, input int idx,
                        input int op, input bit data);
    wr_en[d]   = en;
    wr_idx[d]  = 3'(idx);
    wr_op[d]   = 2'(op);
    wr_data[d] = data;
  endtask

  task automatic set_rd(input int d, input int k, input int idx);
    rd_idx[d][k] = 3'(idx);
  endtask

  task automatic rand_inputs();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < NR[d]; k++)
        rd_idx[d][k] = 3'($urandom_range((1 << IW[d]) - 1, 0));
      wr_en[d]   = 1'($urandom_range(1, 0));
      wr_idx[d]  = 3'($urandom_range((1 << IW[d]) - 1, 0));
      wr_op[d]   = 2'($urandom_range(3, 0));
      wr_data[d] = 1'($urandom_range(1, 0));
      save[d]    = ($urandom_range(5, 0) == 0);
      restore[d] = ($urandom_range(5, 0) == 0);
      // Keep restore-while-empty free of other requests.
      if (restore[d] && !m_vld[d]) begin
        save[d]  = 1'b0;
        wr_en[d] = 1'b0;
      end
    end
  endtask

  initial begin
    int   ops [4] = '{0, 1, 2, 3};
    bit   dat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    // Reset values and constant register.
    set_rd(0, 0, 0); set_rd(0, 1, 1);
    #1;
    check("rst P0", a_rd[0], 1'b0);
    check("rst P1", a_rd[1], 1'b0);
    cycle();
    set_rd(0, 0, 2); set_rd(0, 1, 3);
    #1;
    check("rst P2", a_rd[0], 1'b0);
    check("rst P3 const", a_rd[1], 1'b1);
    set_wr(0, 1, 3, 0, 1'b0);
    cycle();
    set_wr(0, 0, 0, 0, 1'b0);
    check("P3 ignores SET 0", a_rd[1], 1'b1);

    // Read-modify-write sequence on P1.
    set_rd(0, 0, 1); set_rd(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      set_wr(0, 1, 1, ops[i], dat[i]);
      cycle();
      check($sformatf("P1 after op%0d", ops[i]), a_rd[0], exp[i]);
      check($sformatf("P0 after op%0d", ops[i]), a_rd[1], 1'b0);
    end
    set_wr(0, 0, 0, 0, 1'b0);
    set_rd(0, 1, 2);
    #1 check("P2 untouched", a_rd[1], 1'b0);

    // Save with a simultaneous write, then restore.
    set_wr(0, 1, 0, 0, 1'b1); cycle();
    set_wr(0, 1, 2, 0, 1'b1); cycle();
    set_wr(0, 1, 0, 0, 1'b0); save[0] = 1'b1; cycle();
    save[0] = 1'b0; set_wr(0, 0, 0, 0, 1'b0);
    set_rd(0, 0, 0);
    check("vld after save", vld[0], 1'b1);
    check("P0 post-write", a_rd[0], 1'b0);
    set_wr(0, 1, 2, 0, 1'b0); cycle();
    set_wr(0, 0, 0, 0, 1'b0);
    restore[0] = 1'b1; cycle();
    restore[0] = 1'b0;
    set_rd(0, 0, 0); set_rd(0, 1, 2);
    #1;
    check("P0 restored", a_rd[0], 1'b1);
    check("P2 restored", a_rd[1], 1'b1);
    check("vld after restore", vld[0], 1'b0);

    // Overflow is sticky; restore while empty is ignored; reset clears.
    save[0] = 1'b1; cycle(); cycle(); save[0] = 1'b0;
    check("ovf after 2 saves", ovf[0], 1'b1);
    restore[0] = 1'b1; cycle(); restore[0] = 1'b0;
    check("ovf sticky", ovf[0], 1'b1);
    check("vld empty", vld[0], 1'b0);
    restore[0] = 1'b1; cycle(); restore[0] = 1'b0;
    check("empty restore P0", a_rd[0], 1'b1);
    check("empty restore P2", a_rd[1], 1'b1);
    save[0] = 1'b1; cycle(); save[0] = 1'b0;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check("rst mid-full vld", vld[0], 1'b0);
    check("rst mid-full ovf", ovf[0], 1'b0);
    check("rst mid-full P0", a_rd[0], 1'b0);

    // Restore beats a write; restore beats a save.
    save[0] = 1'b1; cycle(); save[0] = 1'b0;
    restore[0] = 1'b1; set_wr(0, 1, 1, 0, 1'b1); cycle();
    restore[0] = 1'b0; set_wr(0, 0, 0, 0, 1'b0);
    set_rd(0, 0, 1);
    check("restore drops write", a_rd[0], 1'b0);
    save[0] = 1'b1; cycle();
    restore[0] = 1'b1; cycle();
    save[0] = 1'b0; restore[0] = 1'b0;
    check("save+restore vld", vld[0], 1'b0);
    check("save+restore ovf", ovf[0], 1'b0);

    // Bypass on the wide instance.
    set_rd(1, 0, 5); set_rd(1, 1, 7); set_rd(1, 2, 5);
    set_wr(1, 1, 5, 3, 1'b1);
    #1;
    check("byp port0 P5", b_rd[0], 1'b1);
    check("byp port1 P7", b_rd[1], 1'b1);
    check("byp port2 P5", b_rd[2], 1'b1);
    cycle();
    #1 check("byp second xor", b_rd[0], 1'b0);
    cycle();
    set_wr(1, 0, 0, 0, 1'b0);

    // Non-power-of-two instance: out-of-range writes dropped, reads zero.
    set_wr(2, 1, 6, 0, 1'b1); cycle();
    set_wr(2, 0, 0, 0, 1'b0); set_rd(2, 0, 6);
    #1 check("oor read", c_rd[0], 1'b0);
    set_wr(2, 1, 4, 0, 1'b1); cycle();
    set_wr(2, 0, 0, 0, 1'b0); set_rd(2, 0, 4);
    #1 check("top reg writable", c_rd[0], 1'b1);
    idle_all();
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(199, 0) != 0);
      rand_inputs();
      cycle();
    end
    rst_n = 1'b1;
    idle_all();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
